// File: rtl/mem_arbiter_pkg.sv
// Shared encodings and default timing parameters for the unified-memory arbiter.
package mem_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_t;

  localparam int DEF_LATENCY    = 4;
  localparam int DEF_STARVE_MAX = 2;

endpackage

// File: rtl/mem_arbiter_if.sv
// Request/response and memory-side bundle between the CPU ports, the arbiter and the memory.
interface mem_arb_if #(
  parameter int AW = 16,
  parameter int DW = 16
);

  // Handshake: a requester holds req/addr/wdata until it sees gnt in the same cycle;
  // gnt fires only when the arbiter is idle, and valid pulses once per granted access.
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_valid;
  logic [DW-1:0] if_rdata;

  logic          d_req;
  logic          d_wr;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_gnt;
  logic          d_valid;
  logic [DW-1:0] d_rdata;

  logic          mem_enable;
  logic          mem_wr;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          busy;

  modport slave (
    input  if_req, if_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata,
    output if_gnt, if_valid, if_rdata, d_gnt, d_valid, d_rdata,
    output mem_enable, mem_wr, mem_addr, mem_wdata, busy
  );

  modport master (
    output if_req, if_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata,
    input  if_gnt, if_valid, if_rdata, d_gnt, d_valid, d_rdata,
    input  mem_enable, mem_wr, mem_addr, mem_wdata, busy
  );

endinterface

// File: rtl/mem_arbiter_arb_prio.sv
// Data-over-fetch priority pick with a saturating counter that forces fetch
// after STARVE_MAX consecutive data grants taken while fetch was waiting.
module arb_prio
  import mem_arb_pkg::*;
#(
  parameter int STARVE_MAX = DEF_STARVE_MAX
) (
  input  logic clk,
  input  logic rst_n,
  input  logic idle,
  input  logic if_req,
  input  logic d_req,
  output logic if_gnt,
  output logic d_gnt
);

  localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  logic [SW-1:0] starve_cnt;
  logic [SW-1:0] starve_n;
  logic          starved;

  always_comb begin
    starved  = (starve_cnt == SW'(STARVE_MAX));
    if_gnt   = idle & if_req & (~d_req | starved);
    d_gnt    = idle & d_req & ~if_gnt;
    starve_n = starve_cnt;
    if (d_gnt && if_req) begin
      if (!starved) starve_n = starve_cnt + 1'b1;
    end else if (idle && (if_gnt || !if_req)) begin
      starve_n = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) starve_cnt <= '0;
    else        starve_cnt <= starve_n;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one multi-cycle single-port memory between instruction fetch and data
// accesses; each access holds the memory inputs for LATENCY cycles.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int LATENCY    = DEF_LATENCY,
  parameter int STARVE_MAX = DEF_STARVE_MAX,
  parameter int AW         = 16,
  parameter int DW         = 16
) (
  input  logic   clk,
  input  logic   rst_n,
  mem_arb_if.slave bus,
  output state_t dbg_state
);

  localparam int CW = (LATENCY <= 1) ? 1 : $clog2(LATENCY);

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [AW-1:0] lat_addr;
  logic          lat_wr;
  logic [DW-1:0] lat_wdata;
  owner_t        lat_owner;
  logic          if_gnt, d_gnt;
  logic          grant, done;
  logic          in_busy;

  arb_prio #(.STARVE_MAX(STARVE_MAX)) u_prio (
    .clk    (clk),
    .rst_n  (rst_n),
    .idle   (state == IDLE),
    .if_req (bus.if_req),
    .d_req  (bus.d_req),
    .if_gnt (if_gnt),
    .d_gnt  (d_gnt)
  );

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    grant   = if_gnt | d_gnt;
    done    = 1'b0;
    case (state)
      IDLE: begin
        if (grant) begin
          state_n = BUSY;
          cnt_n   = CW'(LATENCY - 1);
        end
      end
      BUSY: begin
        if (cnt == '0) begin
          done    = 1'b1;
          state_n = IDLE;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Request inputs may change right after gnt, so the memory is fed from these latches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_addr  <= '0;
      lat_wr    <= 1'b0;
      lat_wdata <= '0;
      lat_owner <= OWN_IF;
    end else if (grant) begin
      lat_addr  <= d_gnt ? bus.d_addr : bus.if_addr;
      lat_wr    <= d_gnt & bus.d_wr;
      lat_wdata <= d_gnt ? bus.d_wdata : '0;
      lat_owner <= d_gnt ? OWN_D : OWN_IF;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.if_valid <= 1'b0;
      bus.d_valid  <= 1'b0;
      bus.if_rdata <= '0;
      bus.d_rdata  <= '0;
    end else begin
      bus.if_valid <= done & (lat_owner == OWN_IF);
      bus.d_valid  <= done & (lat_owner == OWN_D);
      if (done && lat_owner == OWN_IF) bus.if_rdata <= bus.mem_rdata;
      // A write completion only acks; d_rdata keeps the last read value.
      if (done && lat_owner == OWN_D && !lat_wr) bus.d_rdata <= bus.mem_rdata;
    end
  end

  assign in_busy        = (state == BUSY);
  assign bus.if_gnt     = if_gnt;
  assign bus.d_gnt      = d_gnt;
  assign bus.busy       = in_busy;
  assign bus.mem_enable = in_busy;
  assign bus.mem_wr     = in_busy & lat_wr;
  assign bus.mem_addr   = in_busy ? lat_addr : '0;
  assign bus.mem_wdata  = in_busy ? lat_wdata : '0;
  assign dbg_state      = state;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random traffic against a
// transaction-level model of arbitration, access timing and memory contents.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int L    = 4;
  localparam int SMAX = 2;

  // clock / reset
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_arb_if #(.AW(16), .DW(16)) b0 ();
  mem_arb_if #(.AW(16), .DW(16)) b1 ();
  state_t st0, st1;

  mem_arbiter #(.LATENCY(L), .STARVE_MAX(SMAX), .AW(16), .DW(16)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(b0), .dbg_state(st0)
  );
  mem_arbiter #(.LATENCY(1), .STARVE_MAX(SMAX), .AW(16), .DW(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(b1), .dbg_state(st1)
  );

  // memory1c-style array shared by both instances (dut1 only reads)
  logic [15:0] mem_arr [0:1023];
  logic [15:0] ref_mem [0:1023];
  assign b0.mem_rdata = mem_arr[b0.mem_addr[9:0]];
  assign b1.mem_rdata = mem_arr[b1.mem_addr[9:0]];
  always @(posedge clk) if (b0.mem_enable && b0.mem_wr) mem_arr[b0.mem_addr[9:0]] <= b0.mem_wdata;

  int n_assert = 0;
  int n_fail   = 0;

  // transaction model state
  int          cyc;
  int          g;
  bit          has_acc;
  owner_t      a_own;
  logic        a_wr;
  logic [15:0] a_addr, a_wdata;
  int          starve;
  bit          if_pend, d_pend, if_out, d_out, d_hold, rnd_en;
  logic [15:0] p_if_addr, p_d_addr, p_d_wdata;
  logic        p_d_wr;
  logic [15:0] exp_if_rdata, exp_d_rdata;
  logic [15:0] if_exp_q[$];
  logic [15:0] d_exp_q[$];
  // observations
  int          obs_if_gnt, obs_d_gnt, obs_if_valid, obs_d_valid, memwr_cnt;
  logic [15:0] obs_if_rd, obs_d_rd, last_d_rdata;
  int          gnt_log[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    has_acc = 0; g = -1000; starve = 0;
    if_pend = 0; d_pend = 0; if_out = 0; d_out = 0; d_hold = 0;
    exp_if_rdata = '0; exp_d_rdata = '0; last_d_rdata = '0;
    if_exp_q.delete(); d_exp_q.delete();
  endtask

  task automatic clear_obs();
    obs_if_gnt = -1; obs_d_gnt = -1; obs_if_valid = -1; obs_d_valid = -1;
    memwr_cnt = 0; obs_if_rd = 'x; obs_d_rd = 'x;
  endtask

  // One clock of driver + checker + model; entered and left at a posedge.
  task automatic cycle();
    bit in_flight, valid_now, idle, fw, dw;
    cyc++;
    in_flight = has_acc && cyc > g && cyc <= g + L;
    valid_now = has_acc && cyc == g + L + 1;
    if (valid_now) begin
      if (a_own == OWN_IF) begin
        if_out = 0;
        if (if_exp_q.size() > 0) exp_if_rdata = if_exp_q.pop_front();
      end else begin
        d_out = 0;
        if (!a_wr && d_exp_q.size() > 0) exp_d_rdata = d_exp_q.pop_front();
      end
    end
    #1;
    if (d_hold && !d_pend && !d_out) d_pend = 1;
    if (rnd_en) begin
      if (!if_pend && !if_out && $urandom_range(0, 2) == 0) begin
        if_pend = 1; p_if_addr = 16'($urandom_range(64, 127));
      end
      if (!d_pend && !d_out && $urandom_range(0, 2) == 0) begin
        d_pend = 1; p_d_wr = 1'($urandom_range(0, 1));
        p_d_addr = 16'($urandom_range(64, 127)); p_d_wdata = 16'($urandom);
      end
    end
    b0.if_req  = if_pend;
    b0.if_addr = if_pend ? p_if_addr : 16'($urandom);
    b0.d_req   = d_pend;
    b0.d_wr    = d_pend ? p_d_wr : 1'($urandom);
    b0.d_addr  = d_pend ? p_d_addr : 16'($urandom);
    b0.d_wdata = d_pend ? p_d_wdata : 16'($urandom);
    #1;
    idle = !in_flight;
    fw   = idle && if_pend && (!d_pend || starve == SMAX);
    dw   = idle && d_pend && !fw;
    chk("if_gnt", 32'(b0.if_gnt), 32'(fw));
    chk("d_gnt", 32'(b0.d_gnt), 32'(dw));
    chk("gnt_excl", 32'(b0.if_gnt & b0.d_gnt), 32'(0));
    chk("busy", 32'(b0.busy), 32'(in_flight));
    chk("mem_enable", 32'(b0.mem_enable), 32'(in_flight));
    chk("mem_wr", 32'(b0.mem_wr), 32'(in_flight && a_wr));
    chk("mem_addr", 32'(b0.mem_addr), in_flight ? 32'(a_addr) : 32'(0));
    if (!in_flight || a_wr) chk("mem_wdata", 32'(b0.mem_wdata), in_flight ? 32'(a_wdata) : 32'(0));
    chk("if_valid", 32'(b0.if_valid), 32'(valid_now && a_own == OWN_IF));
    chk("d_valid", 32'(b0.d_valid), 32'(valid_now && a_own == OWN_D));
    chk("if_rdata", 32'(b0.if_rdata), 32'(exp_if_rdata));
    chk("d_rdata", 32'(b0.d_rdata), 32'(exp_d_rdata));
    if (b0.if_gnt === 1'b1) begin obs_if_gnt = cyc; gnt_log.push_back(0); end
    if (b0.d_gnt === 1'b1) begin obs_d_gnt = cyc; gnt_log.push_back(1); end
    if (b0.if_valid === 1'b1) begin obs_if_valid = cyc; obs_if_rd = b0.if_rdata; end
    if (b0.d_valid === 1'b1) begin obs_d_valid = cyc; obs_d_rd = b0.d_rdata; end
    if (b0.mem_wr === 1'b1) memwr_cnt++;
    last_d_rdata = b0.d_rdata;
    if (fw) begin
      g = cyc; has_acc = 1; a_own = OWN_IF; a_wr = 0; a_addr = p_if_addr; a_wdata = '0;
      if_exp_q.push_back(ref_mem[p_if_addr[9:0]]);
      if_pend = 0; if_out = 1; starve = 0;
    end else if (dw) begin
      g = cyc; has_acc = 1; a_own = OWN_D; a_wr = p_d_wr; a_addr = p_d_addr; a_wdata = p_d_wdata;
      if (p_d_wr) ref_mem[p_d_addr[9:0]] = p_d_wdata;
      else d_exp_q.push_back(ref_mem[p_d_addr[9:0]]);
      d_pend = 0; d_out = 1;
      starve = if_pend ? ((starve < SMAX) ? starve + 1 : SMAX) : 0;
    end else if (idle && !if_pend) begin
      starve = 0;
    end
    @(posedge clk);
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && (if_pend || d_pend || if_out || d_out); i++) cycle();
    chk("drain_done", 32'({if_pend, d_pend, if_out, d_out}), 32'(0));
  endtask

  initial begin
    int t0;
    logic [15:0] prev_d;
    logic [15:0] v;
    int gl0, gl1, gl2;
    for (int i = 0; i < 1024; i++) begin
      v = 16'($urandom);
      mem_arr[i] = v;
      ref_mem[i] = v;
    end
    mem_arr[16'h0010] = 16'hA5C3;
    ref_mem[16'h0010] = 16'hA5C3;
    b0.if_req = 0; b0.if_addr = '0; b0.d_req = 0; b0.d_wr = 0; b0.d_addr = '0; b0.d_wdata = '0;
    b1.if_req = 0; b1.if_addr = '0; b1.d_req = 0; b1.d_wr = 0; b1.d_addr = '0; b1.d_wdata = '0;
    p_if_addr = '0; p_d_addr = '0; p_d_wdata = '0; p_d_wr = 0; rnd_en = 0;
    model_reset();
    clear_obs();
    cyc = 0;

    // reset values
    #12;
    chk("rst_busy", 32'(b0.busy), 32'(0));
    chk("rst_mem_enable", 32'(b0.mem_enable), 32'(0));
    chk("rst_mem_addr", 32'(b0.mem_addr), 32'(0));
    chk("rst_if_valid", 32'(b0.if_valid), 32'(0));
    chk("rst_d_valid", 32'(b0.d_valid), 32'(0));
    chk("rst_if_rdata", 32'(b0.if_rdata), 32'(0));
    chk("rst_d_rdata", 32'(b0.d_rdata), 32'(0));
    chk("rst_state", 32'(st0), 32'(IDLE));
    chk("rst_l1_busy", 32'(b1.busy), 32'(0));
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);

    // LATENCY=1 fetch: gnt t0, mem_enable t1 only, if_valid t2
    #1 b1.if_req = 1; b1.if_addr = 16'h0010;
    #1 chk("l1_gnt", 32'(b1.if_gnt), 32'(1));
    @(posedge clk);
    #1 b1.if_req = 0;
    #1 chk("l1_en_t1", 32'(b1.mem_enable), 32'(1));
    chk("l1_addr_t1", 32'(b1.mem_addr), 32'h0010);
    chk("l1_valid_t1", 32'(b1.if_valid), 32'(0));
    @(posedge clk);
    #2 chk("l1_en_t2", 32'(b1.mem_enable), 32'(0));
    chk("l1_valid_t2", 32'(b1.if_valid), 32'(1));
    chk("l1_rdata", 32'(b1.if_rdata), 32'hA5C3);
    @(posedge clk);
    #2 chk("l1_valid_t3", 32'(b1.if_valid), 32'(0));
    @(posedge clk);

    // fetch only
    clear_obs();
    if_pend = 1; p_if_addr = 16'h0010; t0 = cyc + 1;
    run(6);
    chk("f_gnt_cycle", 32'(obs_if_gnt), 32'(t0));
    chk("f_valid_cycle", 32'(obs_if_valid), 32'(t0 + 5));
    chk("f_rdata", 32'(obs_if_rd), 32'hA5C3);

    // data write then read back
    clear_obs();
    prev_d = last_d_rdata;
    d_pend = 1; p_d_wr = 1; p_d_addr = 16'h0200; p_d_wdata = 16'h1234; t0 = cyc + 1;
    run(6);
    chk("w_memwr_cycles", 32'(memwr_cnt), 32'(4));
    chk("w_valid_cycle", 32'(obs_d_valid), 32'(t0 + 5));
    chk("w_rdata_hold", 32'(obs_d_rd), 32'(prev_d));
    clear_obs();
    d_pend = 1; p_d_wr = 0; p_d_addr = 16'h0200;
    run(6);
    chk("r_rdata", 32'(obs_d_rd), 32'h1234);

    // contention with both held: D, D, then forced IF
    gnt_log.delete();
    if_pend = 1; p_if_addr = 16'h0020;
    d_pend = 1; p_d_wr = 0; p_d_addr = 16'h0021; d_hold = 1;
    run(12);
    d_hold = 0;
    drain();
    gl0 = (gnt_log.size() > 0) ? gnt_log[0] : -1;
    gl1 = (gnt_log.size() > 1) ? gnt_log[1] : -1;
    gl2 = (gnt_log.size() > 2) ? gnt_log[2] : -1;
    chk("starve_gnt0_d", 32'(gl0), 32'(1));
    chk("starve_gnt1_d", 32'(gl1), 32'(1));
    chk("starve_gnt2_if", 32'(gl2), 32'(0));

    // fetch request arriving mid data access
    clear_obs();
    d_pend = 1; p_d_wr = 0; p_d_addr = 16'h0030; t0 = cyc + 1;
    run(2);
    if_pend = 1; p_if_addr = 16'h0031;
    run(9);
    chk("busy_if_gnt", 32'(obs_if_gnt), 32'(t0 + 5));
    chk("busy_if_valid", 32'(obs_if_valid), 32'(t0 + 10));
    drain();

    // async reset in the middle of an access
    if_pend = 1; p_if_addr = 16'h0010;
    run(3);
    #3 rst_n = 1'b0; b0.if_req = 0;
    #1 chk("abort_mem_enable", 32'(b0.mem_enable), 32'(0));
    chk("abort_busy", 32'(b0.busy), 32'(0));
    chk("abort_mem_addr", 32'(b0.mem_addr), 32'(0));
    chk("abort_state", 32'(st0), 32'(IDLE));
    repeat (2) begin
      @(posedge clk);
      #2 chk("abort_no_valid", 32'(b0.if_valid), 32'(0));
    end
    #3 rst_n = 1'b1;
    model_reset();
    @(posedge clk);
    run(8);
    clear_obs();
    if_pend = 1; p_if_addr = 16'h0010; t0 = cyc + 1;
    run(6);
    chk("post_rst_valid", 32'(obs_if_valid), 32'(t0 + 5));
    chk("post_rst_rdata", 32'(obs_if_rd), 32'hA5C3);

    // random mixed traffic
    rnd_en = 1;
    run(500);
    rnd_en = 0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
